// File: rtl/gol_engine.sv
// Game of Life B3/S23 generation engine: raster-scans a 256x256 toroidal grid on RAM port B.
// Optional macro GOL_AGE_EN: also maintains a saturating 2-bit cell age in bits[3:2].
module gol_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        bank,
  output logic [16:0] live_count,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [3:0]  ram_din,
  input  logic [3:0]  ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RTOP, S_RMID, S_RBOT, S_CAP, S_WR, S_FIN
  } state_t;

  // Which column the current read sequence is filling.
  typedef enum logic [1:0] {
    P_LEFT, P_CENTRE, P_CELL
  } phase_t;

  state_t r_state;
  phase_t r_phase;

  logic [7:0]       r_x;
  logic [7:0]       r_y;
  logic [7:0]       r_cx;
  logic [3:0]       r_top;
  logic [3:0]       r_mid;
  logic [2:0][3:0]  r_lcol;
  logic [2:0][3:0]  r_ccol;
  logic [2:0][3:0]  r_rcol;
  logic [16:0]      r_acc;
  logic             r_next;

  logic [2:0][3:0]  w_ncol;
  logic [2:0]       w_lbit;
  logic [2:0]       w_cbit;
  logic [2:0]       w_rbit;
  logic [3:0]       w_n;
  logic             w_alive;
  logic             w_next;
  logic [1:0]       w_age;
  logic [3:0]       w_din;

  // Column being completed this cycle; bottom arrives straight from the RAM in CAP.
  assign w_ncol = {ram_dout, r_mid, r_top};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rows
      assign w_lbit[gi] = r_lcol[gi][bank];
      assign w_cbit[gi] = r_ccol[gi][bank];
      assign w_rbit[gi] = w_ncol[gi][bank];
    end
  endgenerate

  assign w_alive = w_cbit[1];
  assign w_n = 4'(w_lbit[0]) + 4'(w_lbit[1]) + 4'(w_lbit[2])
             + 4'(w_cbit[0]) + 4'(w_cbit[2])
             + 4'(w_rbit[0]) + 4'(w_rbit[1]) + 4'(w_rbit[2]);
  assign w_next = (w_n == 4'd3) | ((w_n == 4'd2) & w_alive);

`ifdef GOL_AGE_EN
  always_comb begin
    w_age = 2'd0;
    if (w_alive & w_next) begin
      w_age = (r_ccol[1][3:2] == 2'd3) ? 2'd3 : r_ccol[1][3:2] + 2'd1;
    end
  end
`else
  assign w_age = r_ccol[1][3:2];
`endif

  assign w_din = bank ? {w_age, w_alive, w_next} : {w_age, w_next, w_alive};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= P_LEFT;
      busy       <= 1'b0;
      done       <= 1'b0;
      bank       <= 1'b0;
      live_count <= 17'd0;
      ram_addr   <= 16'd0;
      ram_we     <= 1'b0;
      ram_din    <= 4'd0;
      r_x        <= 8'd0;
      r_y        <= 8'd0;
      r_cx       <= 8'd0;
      r_top      <= 4'd0;
      r_mid      <= 4'd0;
      r_lcol     <= '0;
      r_ccol     <= '0;
      r_rcol     <= '0;
      r_acc      <= 17'd0;
      r_next     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            r_x      <= 8'd0;
            r_y      <= 8'd0;
            r_cx     <= 8'hFF;
            r_phase  <= P_LEFT;
            r_acc    <= 17'd0;
            ram_addr <= {8'hFF, 8'hFF};
            r_state  <= S_RTOP;
          end
        end
        S_RTOP: begin
          ram_addr <= {r_y, r_cx};
          r_state  <= S_RMID;
        end
        S_RMID: begin
          r_top    <= ram_dout;
          ram_addr <= {r_y + 8'd1, r_cx};
          r_state  <= S_RBOT;
        end
        S_RBOT: begin
          r_mid   <= ram_dout;
          r_state <= S_CAP;
        end
        S_CAP: begin
          case (r_phase)
            P_LEFT: begin
              r_lcol   <= r_ccol;
              r_ccol   <= w_ncol;
              r_phase  <= P_CENTRE;
              r_cx     <= r_x;
              ram_addr <= {r_y - 8'd1, r_x};
              r_state  <= S_RTOP;
            end
            P_CENTRE: begin
              r_lcol   <= r_ccol;
              r_ccol   <= w_ncol;
              r_phase  <= P_CELL;
              r_cx     <= r_x + 8'd1;
              ram_addr <= {r_y - 8'd1, r_x + 8'd1};
              r_state  <= S_RTOP;
            end
            default: begin
              // Window is complete: the write of the centre cell is issued for the WR cycle.
              r_rcol   <= w_ncol;
              r_next   <= w_next;
              ram_addr <= {r_y, r_x};
              ram_we   <= 1'b1;
              ram_din  <= w_din;
              r_state  <= S_WR;
            end
          endcase
        end
        S_WR: begin
          ram_we  <= 1'b0;
          ram_din <= 4'd0;
          r_lcol  <= r_ccol;
          r_ccol  <= r_rcol;
          r_acc   <= r_acc + 17'(r_next);
          if (r_x == 8'hFF) begin
            if (r_y == 8'hFF) begin
              done       <= 1'b1;
              bank       <= ~bank;
              live_count <= r_acc + 17'(r_next);
              busy       <= 1'b0;
              r_state    <= S_FIN;
            end else begin
              r_x      <= 8'd0;
              r_y      <= r_y + 8'd1;
              r_cx     <= 8'hFF;
              r_phase  <= P_LEFT;
              ram_addr <= {r_y, 8'hFF};
              r_state  <= S_RTOP;
            end
          end else begin
            r_x      <= r_x + 8'd1;
            r_cx     <= r_x + 8'd2;
            ram_addr <= {r_y - 8'd1, r_x + 8'd2};
            r_state  <= S_RTOP;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gol_engine.sv
// Bench for gol_engine: RAM model, array-based Life reference, per-cycle output comparison.
`timescale 1ns/1ps
module tb_gol_engine;
  localparam int GEN_CYC = 329728;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, bank, ram_we;
  logic [16:0] live_count;
  logic [15:0] ram_addr;
  logic [3:0]  ram_din, ram_dout;

  gol_engine dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bank(bank),
    .live_count(live_count), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [3:0] mem     [0:65535];
  logic [3:0] cur_img [0:65535];
  logic [3:0] nxt_img [0:65535];
  logic [3:0] snap    [0:65535];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 65536; i++) mem[i] <= cur_img[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  int   checks = 0;
  int   errors = 0;
  int   trk = 0;
  int   k = 0;
  int   gens_done = 0;
  int   m_live = 0;
  int   exp_live = 0;
  logic m_bank = 1'b0;
  logic samp_start, samp_rst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int idx(input int x, input int y);
    return ((y & 255) << 8) | (x & 255);
  endfunction

  // Life rule on the snapshot of the current generation.
  function automatic logic [3:0] cell_next(input int x, input int y, input logic b);
    int n;
    int a;
    logic alive, nxt;
    logic [1:0] age;
    logic [3:0] res;
    n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) n += int'(cur_img[idx(x + dx, y + dy)][b]);
    alive = cur_img[idx(x, y)][b];
    nxt = (n == 3) || (n == 2 && alive);
    a = int'(cur_img[idx(x, y)][3:2]);
`ifdef GOL_AGE_EN
    if (alive && nxt) begin
      a = a + 1;
      if (a > 3) a = 3;
    end else begin
      a = 0;
    end
`endif
    age = 2'(a);
    res = {age, 2'b00};
    res[b] = alive;
    res[!b] = nxt;
    return res;
  endfunction

  // One clock: sample inputs at the edge, then compare outputs mid-cycle.
  task automatic step();
    logic        e_we;
    logic [15:0] e_addr;
    logic [3:0]  e_din;
    int row, off, x;
    @(posedge clk);
    samp_start = start;
    samp_rst = rst;
    @(negedge clk);
    if (rst) begin
      trk = 0;
      m_bank = 1'b0;
      m_live = 0;
      check("reset_outputs", 64'({busy, done, bank, live_count, ram_addr, ram_we, ram_din}), 64'(0));
    end else begin
      if (trk == 0 && samp_start && !samp_rst) begin
        trk = 1;
        k = 0;
      end
      if (trk != 0) begin
        k++;
        e_we = 1'b0;
        e_addr = 16'h0;
        e_din = 4'h0;
        if (k <= GEN_CYC) begin
          row = (k - 1) / 1288;
          off = (k - 1) % 1288;
          if (off >= 8 && (off - 8) % 5 == 4) begin
            x = (off - 8) / 5;
            e_we = 1'b1;
            e_addr = 16'(row * 256 + x);
            e_din = cell_next(x, row, m_bank);
          end
        end
        if (k == GEN_CYC + 1) begin
          m_bank = !m_bank;
          m_live = exp_live;
        end
        check("gen_ctrl", 64'({busy, done, bank, live_count}),
              64'({(k <= GEN_CYC), (k == GEN_CYC + 1), m_bank, 17'(m_live)}));
        check("gen_write", 64'({ram_we, (e_we ? ram_addr : 16'h0), ram_din}),
              64'({e_we, e_addr, e_din}));
        if (k == GEN_CYC + 1) begin
          trk = 0;
          gens_done++;
        end
      end else begin
        check("idle", 64'({busy, done, bank, live_count, ram_we, ram_din}),
              64'({2'b00, m_bank, 17'(m_live), 1'b0, 4'h0}));
      end
    end
  endtask

  task automatic load_mem();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    step();
  endtask

  task automatic run_gen(input int pulse_at);
    int n, g0, bad;
    g0 = gens_done;
    exp_live = 0;
    for (int y = 0; y < 256; y++)
      for (int x = 0; x < 256; x++) begin
        nxt_img[idx(x, y)] = cell_next(x, y, m_bank);
        exp_live += int'(nxt_img[idx(x, y)][!m_bank]);
      end
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (gens_done == g0 && n < GEN_CYC + 20 && errors < 50) begin
      if (n == pulse_at) start = 1'b1;
      step();
      start = 1'b0;
      n++;
    end
    check("done_seen", 64'(gens_done - g0), 64'(1));
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== nxt_img[i]) bad++;
    check("grid_vs_model", 64'(bad), 64'(0));
  endtask

  function automatic int region_live(input logic b);
    int c = 0;
    for (int y = 0; y < 256; y++)
      for (int x = 0; x < 256; x++)
        if ((x < 140 || x > 190 || y < 140 || y > 190) && nxt_img[idx(x, y)][b]) c++;
    return c;
  endfunction

  task automatic set_live(input int x, input int y);
    cur_img[idx(x, y)] = 4'b0001;
  endtask

  initial begin
    // Reset held with start asserted, released together.
    rst = 1'b1;
    start = 1'b1;
    repeat (6) step();
    rst = 1'b0;
    start = 1'b0;
    repeat (5) step();

    // Random background bits above bit0, random soup, and the named patterns.
    for (int i = 0; i < 65536; i++)
      cur_img[i] = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0};
    for (int y = 150; y <= 180; y++)
      for (int x = 150; x <= 180; x++)
        cur_img[idx(x, y)][0] = ($urandom_range(0, 99) < 35);
    set_live(10, 20); set_live(11, 20); set_live(12, 20);
    set_live(100, 50); set_live(101, 50); set_live(100, 51); set_live(101, 51);
    set_live(255, 0); set_live(0, 0); set_live(1, 0);
    load_mem();

    run_gen(1000);
    check("gen1_bank", 64'(bank), 64'(1));
    check("model_pin_live1", 64'(region_live(1'b1)), 64'(10));
    check("blinker_v", 64'({mem[idx(11, 19)][1], mem[idx(11, 20)][1], mem[idx(11, 21)][1]}), 64'(3'b111));
    check("blinker_ends", 64'({mem[idx(10, 20)][1], mem[idx(12, 20)][1]}), 64'(2'b00));
    check("wrap_v", 64'({mem[idx(0, 255)][1], mem[idx(0, 0)][1], mem[idx(0, 1)][1]}), 64'(3'b111));
    check("wrap_ends", 64'({mem[idx(255, 0)][1], mem[idx(1, 0)][1]}), 64'(2'b00));
    check("block_g1", 64'({mem[idx(100, 50)][1:0], mem[idx(101, 50)][1:0], mem[idx(100, 51)][1:0], mem[idx(101, 51)][1:0]}), 64'(8'hFF));
`ifdef GOL_AGE_EN
    check("age_block_g1", 64'(mem[idx(100, 50)][3:2]), 64'(1));
    check("age_born", 64'(mem[idx(11, 19)][3:2]), 64'(0));
`endif

    for (int i = 0; i < 65536; i++) cur_img[i] = nxt_img[i];
    load_mem();
    run_gen(0);
    check("gen2_bank", 64'(bank), 64'(0));
    check("model_pin_live2", 64'(region_live(1'b0)), 64'(10));
    check("blinker_h", 64'({mem[idx(10, 20)][0], mem[idx(11, 20)][0], mem[idx(12, 20)][0], mem[idx(11, 19)][0]}), 64'(4'b1110));
    check("block_g2", 64'({mem[idx(100, 50)][0], mem[idx(101, 50)][0], mem[idx(100, 51)][0], mem[idx(101, 51)][0]}), 64'(4'hF));
    check("wrap_h", 64'({mem[idx(255, 0)][0], mem[idx(0, 0)][0], mem[idx(1, 0)][0]}), 64'(3'b111));
`ifdef GOL_AGE_EN
    check("age_block_g2", 64'(mem[idx(101, 51)][3:2]), 64'(2));
`endif

    // Abort a generation part-way through.
    for (int i = 0; i < 65536; i++) cur_img[i] = nxt_img[i];
    load_mem();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5000) step();
    rst = 1'b1;
    step();
    check("abort_state", 64'({busy, bank, ram_we}), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 65536; i++) snap[i] = mem[i];
    repeat (20) step();
    begin
      int diff = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== snap[i]) diff++;
      check("no_writes_after_abort", 64'(diff), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
